// File: rtl/parking_pkg.sv
// parking_pkg: shared lane state type and lane-kind selectors for the parking gate front end.
// Contents:
//   lane_state_t - per-lane FSM state (IDLE, OPEN, PASSING)
//   ENTRY / EXIT - values for parking_lane_fsm.CHECK_SPACE
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        PASSING
    } lane_state_t;

    localparam bit ENTRY = 1'b1;
    localparam bit EXIT  = 1'b0;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: card, beam, space-flag and event signals between the lanes and parking_logic.
// Modports:
//   slave  - gate controller: receives cards, beams and space flags; drives gates and event pulses
//   master - environment: drives cards, beams and space flags; observes gates and event pulses
interface parking_gate_ctrl_if;
    import parking_pkg::*;

    logic entry_card_valid;
    logic entry_card_uni;
    logic exit_card_valid;
    logic exit_card_uni;
    logic entry_beam;
    logic exit_beam;
    logic uni_is_vacated_space;
    logic is_vacated_space;
    logic entry_gate_open;
    logic exit_gate_open;
    logic entry_rejected;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;

    modport slave (
        input  entry_card_valid, entry_card_uni, exit_card_valid, exit_card_uni,
        input  entry_beam, exit_beam, uni_is_vacated_space, is_vacated_space,
        output entry_gate_open, exit_gate_open, entry_rejected,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
    );

    modport master (
        output entry_card_valid, entry_card_uni, exit_card_valid, exit_card_uni,
        output entry_beam, exit_beam, uni_is_vacated_space, is_vacated_space,
        input  entry_gate_open, exit_gate_open, entry_rejected,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
    );

endinterface

// File: rtl/parking_lane_fsm.sv
// parking_lane_fsm: one lane (debouncer, IDLE/OPEN/PASSING FSM, gate timeout, card class latch).
// Ports:
//   clk, reset        - clock, synchronous active-low reset
//   card_valid_i/uni_i - card strobe and its class
//   beam_i            - raw beam, 1 = blocked
//   uni_space_i/space_i - space flags, consulted only when CHECK_SPACE is set
//   gate_open_o       - registered barrier command
//   rejected_o        - registered one-cycle refusal pulse
//   event_o/event_uni_o - combinational pass-complete request and class, registered by the top
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GATE_TIMEOUT    = 1000,
    parameter bit          CHECK_SPACE     = ENTRY
) (
    input  logic clk,
    input  logic reset,
    input  logic card_valid_i,
    input  logic card_uni_i,
    input  logic beam_i,
    input  logic uni_space_i,
    input  logic space_i,
    output logic gate_open_o,
    output logic rejected_o,
    output logic event_o,
    output logic event_uni_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(GATE_TIMEOUT + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(GATE_TIMEOUT - 1);

    lane_state_t   state_q, state_d;
    logic          cls_q, cls_d;
    logic          lvl_q, lvl_d;
    logic          rej_q, rej_d;
    logic          gate_q, gate_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          space_ok;

    // Debouncer: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        lvl_d  = lvl_q;
        dcnt_d = '0;
        if (beam_i != lvl_q) begin
            if (dcnt_q >= DB_LAST) lvl_d = ~lvl_q;
            else dcnt_d = dcnt_q + 1'b1;
        end
    end

    // The FSM reacts to the registered debounced level, so it trails the level by one cycle.
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        tcnt_d   = '0;
        rej_d    = 1'b0;
        event_o  = 1'b0;
        space_ok = card_uni_i ? uni_space_i : space_i;
        case (state_q)
            IDLE: begin
                if (card_valid_i) begin
                    cls_d = card_uni_i;
                    if (!CHECK_SPACE || space_ok) state_d = OPEN;
                    else rej_d = 1'b1;
                end
            end
            OPEN: begin
                if (lvl_q) state_d = PASSING;
                else if (tcnt_q >= TO_LAST) state_d = IDLE;
                else tcnt_d = tcnt_q + 1'b1;
            end
            PASSING: begin
                if (!lvl_q) begin
                    state_d = IDLE;
                    event_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        gate_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cls_q   <= 1'b0;
            lvl_q   <= 1'b0;
            rej_q   <= 1'b0;
            gate_q  <= 1'b0;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            lvl_q   <= lvl_d;
            rej_q   <= rej_d;
            gate_q  <= gate_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign gate_open_o = gate_q;
    assign rejected_o  = rej_q;
    assign event_uni_o = event_o & cls_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry and exit lane controllers plus event arbitration toward parking_logic.
// Ports:
//   clk, reset - clock, synchronous active-low reset
//   bus        - parking_gate_ctrl_if.slave: cards, beams, space flags in; gates, rejection and
//                class-qualified car_entered/car_exited pulses out (all registered)
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GATE_TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_gate_ctrl_if.slave    bus
);

    logic entry_ev, entry_cls, exit_ev, exit_cls, unused_exit_rej;
    logic ce_q, ce_d, ceu_q, ceu_d, cx_q, cx_d, cxu_q, cxu_d;
    logic pend_q, pend_d, pend_cls_q, pend_cls_d;

    parking_lane_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .GATE_TIMEOUT   (GATE_TIMEOUT),
        .CHECK_SPACE    (ENTRY)
    ) u_entry (
        .clk         (clk),
        .reset       (reset),
        .card_valid_i(bus.entry_card_valid),
        .card_uni_i  (bus.entry_card_uni),
        .beam_i      (bus.entry_beam),
        .uni_space_i (bus.uni_is_vacated_space),
        .space_i     (bus.is_vacated_space),
        .gate_open_o (bus.entry_gate_open),
        .rejected_o  (bus.entry_rejected),
        .event_o     (entry_ev),
        .event_uni_o (entry_cls)
    );

    parking_lane_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .GATE_TIMEOUT   (GATE_TIMEOUT),
        .CHECK_SPACE    (EXIT)
    ) u_exit (
        .clk         (clk),
        .reset       (reset),
        .card_valid_i(bus.exit_card_valid),
        .card_uni_i  (bus.exit_card_uni),
        .beam_i      (bus.exit_beam),
        .uni_space_i (bus.uni_is_vacated_space),
        .space_i     (bus.is_vacated_space),
        .gate_open_o (bus.exit_gate_open),
        .rejected_o  (unused_exit_rej),
        .event_o     (exit_ev),
        .event_uni_o (exit_cls)
    );

    // A colliding entry event is deferred one cycle; the entry lane is back in IDLE by then,
    // so the pending slot can never be needed twice in a row.
    always_comb begin
        pend_d     = entry_ev & exit_ev;
        pend_cls_d = entry_cls;
        cx_d       = exit_ev;
        cxu_d      = exit_ev & exit_cls;
        ce_d       = pend_q | (entry_ev & ~exit_ev);
        ceu_d      = pend_q ? pend_cls_q : (entry_ev & ~exit_ev & entry_cls);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q     <= 1'b0;
            pend_cls_q <= 1'b0;
            ce_q       <= 1'b0;
            ceu_q      <= 1'b0;
            cx_q       <= 1'b0;
            cxu_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_cls_q <= pend_cls_d;
            ce_q       <= ce_d;
            ceu_q      <= ceu_d;
            cx_q       <= cx_d;
            cxu_q      <= cxu_d;
        end
    end

    assign bus.car_entered        = ce_q;
    assign bus.is_uni_car_entered = ceu_q;
    assign bus.car_exited         = cx_q;
    assign bus.is_uni_car_exited  = cxu_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: vector table, directed corner sequences and random traffic against a lane model.
module tb_parking_gate_ctrl;
    import parking_pkg::*;

    localparam int DB = 4;
    localparam int GT = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    parking_gate_ctrl_if bus();

    parking_gate_ctrl #(.DEBOUNCE_CYCLES(DB), .GATE_TIMEOUT(GT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: gate open flag, car-in-beam flag, open age, latched class, debounced level from a sample window.
    bit m_gate[2], m_pass[2], m_cls[2], m_deb[2];
    int m_age[2];
    bit m_hist[2][DB];
    int m_hn[2];
    bit m_delay[$];
    bit e_eg, e_xg, e_rej, e_ce, e_ceu, e_cx, e_cxu;

    int n_ce, n_cx, ce_cyc, cx_cyc;
    bit ce_uni, cx_uni;

    typedef struct packed {
        logic cv, cu, xv, xu, us, gs;
        logic eg, xg, rej, ce, cx;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit cv[2], cu[2], raw[2], ev[2];
        int d;
        cv[0] = bus.entry_card_valid; cv[1] = bus.exit_card_valid;
        cu[0] = bus.entry_card_uni;   cu[1] = bus.exit_card_uni;
        raw[0] = bus.entry_beam;      raw[1] = bus.exit_beam;
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                m_gate[l] = 0; m_pass[l] = 0; m_cls[l] = 0; m_deb[l] = 0; m_age[l] = 0; m_hn[l] = 0;
            end
            m_delay.delete();
            {e_eg, e_xg, e_rej, e_ce, e_ceu, e_cx, e_cxu} = '0;
            return;
        end
        e_rej = 0;
        for (int l = 0; l < 2; l++) begin
            ev[l] = 0;
            if (!m_gate[l]) begin
                if (cv[l]) begin
                    m_cls[l] = cu[l];
                    if (l == 1 || (cu[l] ? bus.uni_is_vacated_space : bus.is_vacated_space)) begin
                        m_gate[l] = 1;
                        m_age[l] = 0;
                    end else e_rej = 1;
                end
            end else if (!m_pass[l]) begin
                if (m_deb[l]) m_pass[l] = 1;
                else begin
                    m_age[l]++;
                    if (m_age[l] >= GT) m_gate[l] = 0;
                end
            end else if (!m_deb[l]) begin
                m_gate[l] = 0;
                m_pass[l] = 0;
                ev[l] = 1;
            end
            for (int i = 0; i < DB - 1; i++) m_hist[l][i] = m_hist[l][i+1];
            m_hist[l][DB-1] = raw[l];
            if (m_hn[l] < DB) m_hn[l]++;
            d = 0;
            for (int i = 0; i < DB; i++) if (m_hist[l][i] != m_deb[l]) d++;
            if (m_hn[l] == DB && d == DB) m_deb[l] = ~m_deb[l];
        end
        e_cx  = ev[1];
        e_cxu = ev[1] & m_cls[1];
        if (m_delay.size() > 0) begin
            e_ce  = 1;
            e_ceu = m_delay.pop_front();
        end else begin
            e_ce  = ev[0] & !ev[1];
            e_ceu = e_ce & m_cls[0];
        end
        if (ev[0] && ev[1]) m_delay.push_back(m_cls[0]);
        e_eg = m_gate[0];
        e_xg = m_gate[1];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        chk("entry_gate_open", bus.entry_gate_open, e_eg);
        chk("exit_gate_open", bus.exit_gate_open, e_xg);
        chk("entry_rejected", bus.entry_rejected, e_rej);
        chk("car_entered", bus.car_entered, e_ce);
        chk("is_uni_car_entered", bus.is_uni_car_entered, e_ceu);
        chk("car_exited", bus.car_exited, e_cx);
        chk("is_uni_car_exited", bus.is_uni_car_exited, e_cxu);
        if (bus.car_entered === 1'b1) begin n_ce++; ce_cyc = cyc; ce_uni = bus.is_uni_car_entered; end
        if (bus.car_exited === 1'b1) begin n_cx++; cx_cyc = cyc; cx_uni = bus.is_uni_car_exited; end
    endtask

    task automatic card(input bit exit_lane, input bit uni);
        if (exit_lane) begin bus.exit_card_valid = 1; bus.exit_card_uni = uni; end
        else begin bus.entry_card_valid = 1; bus.entry_card_uni = uni; end
        tick();
        bus.entry_card_valid = 0;
        bus.exit_card_valid = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_ce = 0; n_cx = 0; ce_cyc = -1; cx_cyc = -1; ce_uni = 0; cx_uni = 0;
    endtask

    initial begin
        int open_cyc;
        tbl[0] = '{0,0,0,0,0,0, 0,0,0,0,0};
        tbl[1] = '{1,0,0,0,1,0, 0,0,1,0,0};
        tbl[2] = '{1,1,0,0,0,1, 0,0,1,0,0};
        tbl[3] = '{0,0,0,0,1,1, 0,0,0,0,0};
        tbl[4] = '{1,1,0,0,1,0, 1,0,0,0,0};
        tbl[5] = '{0,0,0,0,0,0, 1,0,0,0,0};
        tbl[6] = '{0,0,1,1,0,0, 1,1,0,0,0};
        tbl[7] = '{1,0,0,0,0,1, 1,1,0,0,0};
        bus.entry_card_valid = 0; bus.entry_card_uni = 0;
        bus.exit_card_valid = 0;  bus.exit_card_uni = 0;
        bus.entry_beam = 0; bus.exit_beam = 0;
        bus.uni_is_vacated_space = 0; bus.is_vacated_space = 0;
        clear_counts();
        @(negedge clk);
        ticks(2);
        chk("reset_gates", {bus.entry_gate_open, bus.exit_gate_open}, 0);
        chk("reset_pulses", {bus.entry_rejected, bus.car_entered, bus.car_exited}, 0);
        reset = 1;

        for (int i = 0; i < 8; i++) begin
            bus.entry_card_valid = tbl[i].cv; bus.entry_card_uni = tbl[i].cu;
            bus.exit_card_valid = tbl[i].xv;  bus.exit_card_uni = tbl[i].xu;
            bus.uni_is_vacated_space = tbl[i].us; bus.is_vacated_space = tbl[i].gs;
            tick();
            chk("tbl_entry_gate", bus.entry_gate_open, tbl[i].eg);
            chk("tbl_exit_gate", bus.exit_gate_open, tbl[i].xg);
            chk("tbl_rejected", bus.entry_rejected, tbl[i].rej);
            chk("tbl_events", {bus.car_entered, bus.car_exited}, {tbl[i].ce, tbl[i].cx});
        end
        bus.entry_card_valid = 0;
        bus.exit_card_valid = 0;

        // Both lanes open; both beams fall together: exit first, entry one cycle later.
        clear_counts();
        bus.entry_beam = 1; bus.exit_beam = 1;
        ticks(10);
        bus.entry_beam = 0; bus.exit_beam = 0;
        ticks(8);
        chk("coll_n_exited", n_cx, 1);
        chk("coll_n_entered", n_ce, 1);
        chk("coll_order", ce_cyc, cx_cyc + 1);
        chk("coll_classes", {ce_uni, cx_uni}, 2'b11);
        chk("coll_gates_closed", {bus.entry_gate_open, bus.exit_gate_open}, 0);

        // Short glitches keep the lane in OPEN; a held beam passes the car.
        clear_counts();
        bus.uni_is_vacated_space = 1; bus.is_vacated_space = 0;
        card(0, 1);
        chk("glitch_open", bus.entry_gate_open, 1);
        for (int len = 1; len <= 3; len++) begin
            bus.entry_beam = 1; ticks(len);
            bus.entry_beam = 0; ticks(2);
        end
        chk("glitch_still_open", bus.entry_gate_open, 1);
        chk("glitch_no_event", n_ce, 0);
        bus.entry_beam = 1; ticks(5);
        bus.entry_beam = 0; ticks(6);
        chk("pass_one_event", n_ce, 1);
        chk("pass_uni_class", ce_uni, 1);
        chk("pass_gate_closed", bus.entry_gate_open, 0);

        // Timeout: exit gate open exactly GT cycles, then a fresh card is accepted at once.
        clear_counts();
        card(1, 0);
        open_cyc = bus.exit_gate_open ? 1 : 0;
        for (int i = 0; i < 100 && bus.exit_gate_open; i++) begin
            tick();
            if (bus.exit_gate_open) open_cyc++;
        end
        chk("timeout_open_cycles", open_cyc, GT);
        chk("timeout_closed", bus.exit_gate_open, 0);
        chk("timeout_no_event", n_cx, 0);
        card(1, 1);
        chk("timeout_next_card", bus.exit_gate_open, 1);
        ticks(GT + 2);

        // Reset while the car is in the beam drops the pass.
        clear_counts();
        bus.is_vacated_space = 1;
        card(0, 0);
        bus.entry_beam = 1; ticks(6);
        reset = 0; tick();
        chk("rst_outputs", {bus.entry_gate_open, bus.exit_gate_open, bus.entry_rejected,
                            bus.car_entered, bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited}, 0);
        reset = 1;
        ticks(5);
        bus.entry_beam = 0; ticks(8);
        chk("rst_no_event", n_ce, 0);
        chk("rst_gate_closed", bus.entry_gate_open, 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bus.entry_card_valid = ($urandom_range(0, 7) == 0);
            bus.entry_card_uni = $urandom_range(0, 1);
            bus.exit_card_valid = ($urandom_range(0, 7) == 0);
            bus.exit_card_uni = $urandom_range(0, 1);
            bus.uni_is_vacated_space = $urandom_range(0, 1);
            bus.is_vacated_space = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) bus.entry_beam = ~bus.entry_beam;
            if ($urandom_range(0, 5) == 0) bus.exit_beam = ~bus.exit_beam;
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Gate-side front end for `parking_logic`. Runs one entry lane and one exit lane, each with a card reader, a barrier and a vehicle beam sensor. Admits a car only when `parking_logic` reports room for its class, and converts a debounced beam pass into the single-cycle `car_entered`/`car_exited` pulses with class qualifiers that `parking_logic` counts. All outputs are registered.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive identical beam samples required to change the debounced level (≥1).
- `GATE_TIMEOUT`, 1000: cycles an open gate waits for the beam to block before closing (≥2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low; when 0 on a rising edge, all state is cleared.
- `entry_card_valid`  in  1  one-cycle strobe: card read at entry.
- `entry_card_uni`  in  1  class of the entry card (1 = university), valid with the strobe.
- `exit_card_valid`  in  1  one-cycle strobe: card read at exit.
- `exit_card_uni`  in  1  class of the exit card, valid with the strobe.
- `entry_beam`  in  1  raw entry beam, 1 = blocked.
- `exit_beam`  in  1  raw exit beam, 1 = blocked.
- `uni_is_vacated_space`  in  1  from `parking_logic`: a university space is free.
- `is_vacated_space`  in  1  from `parking_logic`: a general space is free.
- `entry_gate_open`  out  1  entry barrier command.
- `exit_gate_open`  out  1  exit barrier command.
- `entry_rejected`  out  1  one-cycle pulse: entry refused, no space for the class.
- `car_entered`  out  1  one-cycle pulse to `parking_logic`.
- `is_uni_car_entered`  out  1  class of the entering car, valid while `car_entered`=1, 0 otherwise.
- `car_exited`  out  1  one-cycle pulse to `parking_logic`.
- `is_uni_car_exited`  out  1  class of the exiting car, valid while `car_exited`=1, 0 otherwise.

## Operation
Each lane runs the FSM IDLE → OPEN → PASSING → IDLE.
- **IDLE**: gate closed.
  - A card strobe latches the card class.
  - Entry lane: if the class is uni and `uni_is_vacated_space`=1, or the class is non-uni and `is_vacated_space`=1, go to OPEN. Otherwise pulse `entry_rejected` and stay in IDLE.
  - Exit lane: always go to OPEN.
- **OPEN**: gate open; the timeout counter runs.
  - Debounced beam goes to 1: go to PASSING.
  - Counter reaches `GATE_TIMEOUT`: go to IDLE, no event is emitted.
- **PASSING**: gate open; no timeout.
  - Debounced beam goes to 0: go to IDLE and emit the lane's event pulse with the latched class.
- Card strobes outside IDLE are ignored.
- Debouncer, one per beam:
  - Resets to level 0.
  - A sample counter counts consecutive raw samples that differ from the debounced level.
  - The level flips when the count reaches `DEBOUNCE_CYCLES`.
  - Any sample equal to the debounced level clears the count.
- Event arbitration: when both lanes would emit in the same cycle, `car_exited` goes first. The entry event is held in a pending register and emitted the next cycle. At most one pending entry can exist, because the lane is in IDLE by then.
- Reset, including mid-operation:
  - Both FSMs go to IDLE and both gates close.
  - All pulses and class outputs go to 0.
  - Debounced levels and counters go to 0, and the pending entry is dropped.

## Timing
- Reset value of every output is 0.
- Card strobe in IDLE at edge N: the gate is open (or `entry_rejected`=1) from N+1. Latency is 1 cycle.
- Space flags are sampled in the same cycle as the strobe.
- Raw beam high from edge M: the debounced level is 1 after edge M+`DEBOUNCE_CYCLES`−1; the FSM is in PASSING one cycle later.
- Debounced fall at edge K: the gate closes and the event pulse is high during the cycle after K. The pulse is exactly 1 cycle wide; the class output is valid only in that cycle.
- Timeout: the gate is open for exactly `GATE_TIMEOUT` cycles when the beam never blocks.
- A new card strobe is accepted in the first cycle back in IDLE.
- Counter widths are `$clog2(param+1)`; counters saturate and never wrap.

## Structure
- Package `parking_pkg`:
  - `lane_state_t` enum {IDLE, OPEN, PASSING}.
  - Lane-kind constants (ENTRY, EXIT).
- Sub-module `parking_lane_fsm`: debouncer, FSM, timeout counter and class latch. Parameter `CHECK_SPACE` selects entry or exit behaviour.
- The top instantiates two `parking_lane_fsm` instances and holds the event arbitration and pending register.

## Test plan
- `DEBOUNCE_CYCLES`=4. Uni card with `uni_is_vacated_space`=1, beam high 10 cycles then low -> gate open next cycle; exactly one `car_entered` pulse with `is_uni_car_entered`=1; gate closed.
- Non-uni card with `is_vacated_space`=0 -> `entry_rejected` for 1 cycle; gate never opens; no `car_entered`.
- Beam glitches of 1–3 cycles during OPEN -> stays in OPEN, no event. A beam held 4+ cycles -> PASSING.
- `GATE_TIMEOUT`=20, no beam -> gate open exactly 20 cycles, then closed; no event; the next card is accepted.
- Entry and exit debounced falls on the same edge -> `car_exited` in cycle K+1, `car_entered` in cycle K+2, classes correct.
- `reset`=0 while in PASSING -> next cycle all outputs are 0 and the FSM is in IDLE. A beam release after reset produces no event.
